// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl -- rock-paper-scissors round sequencer.
// Runs the round FSM, picks the computer hand, scores each round and keeps
// both scores. Every displayed output changes only on a frame tick (synced
// vsync falling edge), so a frame never shows a half-updated scene.
//
// Parameters:
//   COUNT_FRAMES   frames spent in COUNTDOWN (1..1023)
//   REVEAL_FRAMES  frames spent in REVEAL before RESULT (1..1023)
//   SCORE_MAX      saturating score limit (1..15)
// Ports:
//   clk           in   board clock
//   rst           in   synchronous active-high reset
//   vsync         in   active-low vsync from the VGA controller
//   start         in   one-cycle start pulse
//   hand_valid    in   one-cycle pulse qualifying hand_sel
//   hand_sel      in   0 rock, 1 paper, 2 scissors, 3 none
//   state         out  0 IDLE, 1 COUNTDOWN, 2 REVEAL, 3 RESULT
//   com_hand      out  computer hand, 3 = hidden
//   player_hand   out  player hand, 3 = hidden
//   result        out  0 none, 1 win, 2 lose, 3 draw
//   player_score  out  player score, saturating
//   com_score     out  computer score, saturating
//   busy          out  high in COUNTDOWN and REVEAL
module rps_round_ctrl #(
  parameter int unsigned COUNT_FRAMES  = 180,
  parameter int unsigned REVEAL_FRAMES = 120,
  parameter int unsigned SCORE_MAX     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       start,
  input  logic       hand_valid,
  input  logic [1:0] hand_sel,
  output logic [1:0] state,
  output logic [1:0] com_hand,
  output logic [1:0] player_hand,
  output logic [1:0] result,
  output logic [3:0] player_score,
  output logic [3:0] com_score,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REVEAL = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_WIN  = 2'd1;
  localparam logic [1:0] RES_LOSE = 2'd2;
  localparam logic [1:0] RES_DRAW = 2'd3;
  localparam logic [1:0] HAND_NONE = 2'd3;

  localparam logic [9:0] COUNT_LOAD  = 10'(COUNT_FRAMES - 1);
  localparam logic [9:0] REVEAL_LOAD = 10'(REVEAL_FRAMES - 1);
  localparam logic [3:0] SCORE_LIM   = 4'(SCORE_MAX);

  state_t     st;
  logic [9:0] cnt;
  logic       vs_meta, vs_sync, vs_prev;
  logic       tick;
  logic [1:0] pick;
  logic       start_pend;
  logic [1:0] hand_pend;
  logic [1:0] hand_now;
  logic [1:0] res_now;
  logic       round_go;

  assign state = st;

  // Reset to the idle (high) level so leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign tick = vs_prev & ~vs_sync;

  always_ff @(posedge clk) begin
    if (rst)              pick <= 2'd0;
    else if (pick == 2'd2) pick <= 2'd0;
    else                  pick <= pick + 2'd1;
  end

  // A new round begins on this tick (from IDLE or RESULT with a pending start).
  assign round_go = tick && start_pend && (st == S_IDLE || st == S_RESULT);

  always_ff @(posedge clk) begin
    if (rst)           start_pend <= 1'b0;
    else if (busy)     start_pend <= 1'b0;
    else if (round_go) start_pend <= 1'b0;
    else if (start)    start_pend <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      hand_pend <= HAND_NONE;
    else if (round_go)
      hand_pend <= HAND_NONE;
    else if (st == S_COUNT && hand_valid && hand_sel != HAND_NONE)
      hand_pend <= hand_sel;
  end

  // Bypass so a hand pulse coinciding with the final countdown tick still counts.
  always_comb begin
    hand_now = hand_pend;
    if (st == S_COUNT && hand_valid && hand_sel != HAND_NONE)
      hand_now = hand_sel;
  end

  always_comb begin
    res_now = RES_LOSE;
    if (hand_now == HAND_NONE)
      res_now = RES_LOSE;
    else if (hand_now == pick)
      res_now = RES_DRAW;
    else if ((hand_now == 2'd1 && pick == 2'd0) ||
             (hand_now == 2'd2 && pick == 2'd1) ||
             (hand_now == 2'd0 && pick == 2'd2))
      res_now = RES_WIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      cnt          <= '0;
      com_hand     <= HAND_NONE;
      player_hand  <= HAND_NONE;
      result       <= RES_NONE;
      player_score <= '0;
      com_score    <= '0;
      busy         <= 1'b0;
    end else if (tick) begin
      case (st)
        S_IDLE, S_RESULT: begin
          if (start_pend) begin
            st          <= S_COUNT;
            cnt         <= COUNT_LOAD;
            com_hand    <= HAND_NONE;
            player_hand <= HAND_NONE;
            result      <= RES_NONE;
            busy        <= 1'b1;
          end
        end
        S_COUNT: begin
          if (cnt != '0) begin
            cnt <= cnt - 10'd1;
          end else begin
            st          <= S_REVEAL;
            cnt         <= REVEAL_LOAD;
            com_hand    <= pick;
            player_hand <= hand_now;
            result      <= res_now;
            if (res_now == RES_WIN && player_score < SCORE_LIM)
              player_score <= player_score + 4'd1;
            if (res_now == RES_LOSE && com_score < SCORE_LIM)
              com_score <= com_score + 4'd1;
          end
        end
        S_REVEAL: begin
          if (cnt != '0) begin
            cnt <= cnt - 10'd1;
          end else begin
            st   <= S_RESULT;
            busy <= 1'b0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_round_ctrl.sv
module tb_rps_round_ctrl;

  localparam int unsigned FRAME = 800;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       hand_valid = 1'b0;
  logic [1:0] hand_sel = 2'd3;
  logic [1:0] state, com_hand, player_hand, result;
  logic [3:0] player_score, com_score;
  logic       busy;

  rps_round_ctrl #(
    .COUNT_FRAMES (3),
    .REVEAL_FRAMES(2),
    .SCORE_MAX    (9)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .start       (start),
    .hand_valid  (hand_valid),
    .hand_sel    (hand_sel),
    .state       (state),
    .com_hand    (com_hand),
    .player_hand (player_hand),
    .result      (result),
    .player_score(player_score),
    .com_score   (com_score),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // gcyc: free cycle count for the vsync pattern; cyc: cycles since reset (pick model).
  int unsigned gcyc = 0;
  int unsigned cyc  = 0;
  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    cyc  <= rst ? 0 : cyc + 1;
  end

  always @(negedge clk) vsync <= !((gcyc % FRAME) < 8);

  typedef struct {
    logic [1:0] com;
    logic [1:0] ply;
    logic [1:0] res;
    logic [3:0] ps;
    logic [3:0] cs;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ps_m = 0;
  int   cs_m = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] res_of(input logic [1:0] p, input logic [1:0] c);
    if (p == 2'd3) return 2'd2;
    if (p == c) return 2'd3;
    if (((int'(p) + 3 - int'(c)) % 3) == 1) return 2'd1;
    return 2'd2;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic hv(input logic [1:0] h);
    @(negedge clk);
    hand_valid = 1'b1;
    hand_sel   = h;
    @(negedge clk);
    hand_valid = 1'b0;
    hand_sel   = 2'd3;
  endtask

  task automatic wait_state(input logic [1:0] s, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {6'd0, state}, {6'd0, s});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},  {6'd0, state},       8'd0);
    chk({tag, "_com"},    {6'd0, com_hand},    8'd3);
    chk({tag, "_player"}, {6'd0, player_hand}, 8'd3);
    chk({tag, "_result"}, {6'd0, result},      8'd0);
    chk({tag, "_pscore"}, {4'd0, player_score}, 8'd0);
    chk({tag, "_cscore"}, {4'd0, com_score},    8'd0);
    chk({tag, "_busy"},   {7'd0, busy},         8'd0);
  endtask

  // Called on the first negedge after COUNTDOWN was entered.
  // mode 0: rock then paper (then ignored 'none'); 1: no hand, start while busy,
  // hand in REVEAL; 2: winning hand; 3: no hand.
  task automatic round_body(input int mode);
    logic [1:0] c, p;
    exp_t e;
    // The REVEAL tick is exactly 3 frames (2400 clk, a multiple of 3) after the entry tick.
    c = 2'((cyc - 1) % 3);
    chk("cd_busy",          {7'd0, busy},        8'd1);
    chk("cd_player_hidden", {6'd0, player_hand}, 8'd3);
    chk("cd_com_hidden",    {6'd0, com_hand},    8'd3);
    chk("cd_result_none",   {6'd0, result},      8'd0);
    p = 2'd3;
    case (mode)
      0: begin
        repeat (20) @(negedge clk);
        hv(2'd0);
        repeat (30) @(negedge clk);
        hv(2'd1);
        repeat (10) @(negedge clk);
        hv(2'd3);
        p = 2'd1;
      end
      1: begin
        repeat (50) @(negedge clk);
        pulse_start();
      end
      2: begin
        p = 2'((c + 1) % 3);
        repeat (40) @(negedge clk);
        hv(p);
      end
      default: ;
    endcase
    e.com = c;
    e.ply = p;
    e.res = res_of(p, c);
    if (e.res == 2'd1 && ps_m < 9) ps_m++;
    if (e.res == 2'd2 && cs_m < 9) cs_m++;
    e.ps = 4'(ps_m);
    e.cs = 4'(cs_m);
    sbq.push_back(e);

    wait_state(2'd2, 4 * FRAME, "reveal_entry");
    e = sbq.pop_front();
    chk("rev_com",    {6'd0, com_hand},     {6'd0, e.com});
    chk("rev_player", {6'd0, player_hand},  {6'd0, e.ply});
    chk("rev_result", {6'd0, result},       {6'd0, e.res});
    chk("rev_pscore", {4'd0, player_score}, {4'd0, e.ps});
    chk("rev_cscore", {4'd0, com_score},    {4'd0, e.cs});
    chk("rev_busy",   {7'd0, busy},         8'd1);
    if (mode == 1) begin
      repeat (20) @(negedge clk);
      hv(2'd0);
    end

    wait_state(2'd3, 3 * FRAME, "result_entry");
    chk("res_com",    {6'd0, com_hand},    {6'd0, e.com});
    chk("res_player", {6'd0, player_hand}, {6'd0, e.ply});
    chk("res_result", {6'd0, result},      {6'd0, e.res});
    chk("res_busy",   {7'd0, busy},        8'd0);
    if (mode == 1) begin
      repeat (FRAME + 20) @(negedge clk);
      chk("start_ignored_while_busy", {6'd0, state}, 8'd3);
    end
  endtask

  task automatic round(input int mode);
    pulse_start();
    wait_state(2'd1, 2 * FRAME, "countdown_entry");
    round_body(mode);
  endtask

  initial begin
    // Power-on reset, released mid-frame.
    repeat (400) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Start 100 clk after a tick: no change until the next vsync fall, then state 1 on that edge.
    @(negedge vsync);
    repeat (102) @(negedge clk);
    pulse_start();
    chk("start_wait_state", {6'd0, state}, 8'd0);
    @(negedge vsync);
    chk("start_at_fall", {6'd0, state}, 8'd0);
    repeat (2) @(negedge clk);
    chk("start_tick_cycle", {6'd0, state}, 8'd0);
    @(negedge clk);
    chk("start_edge_state", {6'd0, state}, 8'd1);
    chk("start_edge_busy",  {7'd0, busy},  8'd1);
    round_body(0);

    // Two more rock-then-paper rounds, each shifted by one frame so the pick walks 0/1/2.
    repeat (FRAME) @(negedge clk);
    round(0);
    repeat (FRAME) @(negedge clk);
    round(0);

    // No hand: lose, hand in REVEAL ignored, start during busy dropped.
    round(1);

    // Winning rounds until the player score saturates.
    for (int unsigned i = 0; i < 9; i++) round(2);
    chk("pscore_saturated", {4'd0, player_score}, 8'd9);

    repeat (2 * FRAME) @(negedge clk);
    chk("result_hold_state",  {6'd0, state},  8'd3);
    chk("result_hold_result", {6'd0, result}, 8'd1);
    pulse_start();
    wait_state(2'd1, 2 * FRAME, "restart_entry");
    chk("restart_player_hidden", {6'd0, player_hand}, 8'd3);
    chk("restart_com_hidden",    {6'd0, com_hand},    8'd3);
    chk("restart_result_none",   {6'd0, result},      8'd0);
    chk("restart_pscore_kept",   {4'd0, player_score}, 8'd9);

    // Reset during COUNTDOWN with a pending hand, then a clean round.
    hv(2'd2);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midround_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ps_m = 0;
    cs_m = 0;
    repeat (FRAME) @(negedge clk);
    round(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
